// File: rtl/decode_writeback_stage.sv
// Decode / write-back stage: control decode, register file with write-back, ID-stage forwarding,
// branch resolution and hazard stall. ID/EX word is registered (1 cycle); stall inserts a control bubble.
module decode_writeback_stage (
  input  logic         clk,
  input  logic         reset,
  input  logic [63:0]  IFIDReg,
  input  logic [70:0]  MEMWBReg,
  input  logic [74:0]  EXMEReg,
  output logic [135:0] IDEXReg,
  output logic         BranchControlSignal,
  output logic [31:0]  BranchTarget,
  output logic         pcHOLD
);

  logic [31:0]  r_regs [32];
  logic [135:0] r_idex;

  logic [31:0]  w_instr, w_pc4, w_imm_ext;
  logic [5:0]   w_opcode;
  logic [4:0]   w_rs, w_rt;
  logic [9:0]   w_ctrl;
  logic         w_branch, w_jump;

  logic         w_wb_en;
  logic [4:0]   w_wb_dst;
  logic [31:0]  w_wb_data;

  logic         w_exme_fwd;
  logic [4:0]   w_exme_dst;
  logic [31:0]  w_exme_alu;

  logic [31:0]  w_op1, w_op2;
  logic [4:0]   w_idex_dst;
  logic         w_load_use, w_br_ex, w_br_mem;
  logic [135:0] w_idex_next;
  logic         w_unused;

  assign w_instr   = IFIDReg[63:32];
  assign w_pc4     = IFIDReg[31:0];
  assign w_opcode  = w_instr[31:26];
  assign w_rs      = w_instr[25:21];
  assign w_rt      = w_instr[20:16];
  assign w_imm_ext = {{16{w_instr[15]}}, w_instr[15:0]};

  // {RegDst,MemRead,MemtoReg,ALUOp[1:0],MemWrite,ALUSrc,RegWrite,Branch,Jump}
  always_comb begin
    w_ctrl = 10'b0;
    case (w_opcode)
      6'b000000: w_ctrl = 10'b1_0_0_10_0_0_1_0_0;
      6'b100011: w_ctrl = 10'b0_1_1_00_0_1_1_0_0;
      6'b101011: w_ctrl = 10'b0_0_0_00_1_1_0_0_0;
      6'b000100: w_ctrl = 10'b0_0_0_01_0_0_0_1_0;
      6'b001000: w_ctrl = 10'b0_0_0_00_0_1_1_0_0;
      6'b000010: w_ctrl = 10'b0_0_0_00_0_0_0_0_1;
      default:   w_ctrl = 10'b0;
    endcase
  end
  assign w_branch = w_ctrl[1];
  assign w_jump   = w_ctrl[0];

  assign w_wb_dst  = MEMWBReg[36:32];
  assign w_wb_en   = MEMWBReg[37] && (w_wb_dst != 5'd0);
  assign w_wb_data = MEMWBReg[70] ? MEMWBReg[31:0] : MEMWBReg[69:38];

  // Loads in EX/MEM have no data yet, so they are never a forwarding source.
  assign w_exme_dst = EXMEReg[68:64];
  assign w_exme_alu = EXMEReg[63:32];
  assign w_exme_fwd = EXMEReg[69] && !EXMEReg[70] && (w_exme_dst != 5'd0);

  // MEM/WB forward and register-file write-through yield the same value, so one path covers both.
  always_comb begin
    w_op1 = r_regs[w_rs];
    if (w_rs == 5'd0)                             w_op1 = 32'd0;
    else if (w_exme_fwd && (w_exme_dst == w_rs))  w_op1 = w_exme_alu;
    else if (w_wb_en && (w_wb_dst == w_rs))       w_op1 = w_wb_data;

    w_op2 = r_regs[w_rt];
    if (w_rt == 5'd0)                             w_op2 = 32'd0;
    else if (w_exme_fwd && (w_exme_dst == w_rt))  w_op2 = w_exme_alu;
    else if (w_wb_en && (w_wb_dst == w_rt))       w_op2 = w_wb_data;
  end

  assign w_idex_dst = r_idex[135] ? r_idex[15:11] : r_idex[20:16];
  assign w_load_use = r_idex[134] && ((r_idex[20:16] == w_rs) || (r_idex[20:16] == w_rt));
  assign w_br_ex    = w_branch && r_idex[128] && (w_idex_dst != 5'd0) &&
                      ((w_idex_dst == w_rs) || (w_idex_dst == w_rt));
  assign w_br_mem   = w_branch && EXMEReg[70] && (w_exme_dst != 5'd0) &&
                      ((w_exme_dst == w_rs) || (w_exme_dst == w_rt));

  assign pcHOLD              = w_load_use || w_br_ex || w_br_mem;
  assign BranchControlSignal = w_branch && (w_op1 == w_op2) && !pcHOLD;
  assign BranchTarget        = w_pc4 + {w_imm_ext[29:0], 2'b00};

  assign w_idex_next = {(pcHOLD ? 8'd0 : w_ctrl[9:2]), w_imm_ext, w_op2, w_op1, w_instr};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= 32'd0;
      r_idex <= 136'd0;
    end else begin
      if (w_wb_en) r_regs[w_wb_dst] <= w_wb_data;
      r_idex <= w_idex_next;
    end
  end

  assign IDEXReg  = r_idex;
  assign w_unused = ^{EXMEReg[74:71], EXMEReg[31:0], w_jump};

endmodule

// File: tb/tb_decode_writeback_stage.sv
// Directed bench for decode_writeback_stage: IDEXReg expectations queued at drive time and checked
// after each capturing edge; combinational outputs checked directly against constants.
module tb_decode_writeback_stage;

  logic         clk = 1'b0;
  logic         reset;
  logic [63:0]  IFIDReg;
  logic [70:0]  MEMWBReg;
  logic [74:0]  EXMEReg;
  logic [135:0] IDEXReg;
  logic         BranchControlSignal;
  logic [31:0]  BranchTarget;
  logic         pcHOLD;

  decode_writeback_stage dut (
    .clk                 (clk),
    .reset               (reset),
    .IFIDReg             (IFIDReg),
    .MEMWBReg            (MEMWBReg),
    .EXMEReg             (EXMEReg),
    .IDEXReg             (IDEXReg),
    .BranchControlSignal (BranchControlSignal),
    .BranchTarget        (BranchTarget),
    .pcHOLD              (pcHOLD)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        tag;
    logic [135:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  localparam logic [7:0] C_RTYPE = 8'b1_0_0_10_0_0_1;
  localparam logic [7:0] C_LW    = 8'b0_1_1_00_0_1_1;
  localparam logic [7:0] C_SW    = 8'b0_0_0_00_1_1_0;
  localparam logic [7:0] C_BEQ   = 8'b0_0_0_01_0_0_0;
  localparam logic [7:0] C_BUBL  = 8'b0;

  localparam logic [31:0] I_ADD_3_1_2 = 32'h0022_1820;
  localparam logic [31:0] I_ADD_3_0_1 = 32'h0001_1820;
  localparam logic [31:0] I_ADD_3_2_1 = 32'h0041_1820;
  localparam logic [31:0] I_ADD_4_1_2 = 32'h0022_2020;
  localparam logic [31:0] I_ADD_3_4_5 = 32'h0085_1820;
  localparam logic [31:0] I_BEQ_4_5   = 32'h1085_FFFE;
  localparam logic [31:0] I_LW_2_1    = 32'h8C22_0000;
  localparam logic [31:0] I_SW_7_6    = 32'hACC7_0000;

  task automatic chk(input string tag, input logic [135:0] obs, input logic [135:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [7:0] c, input logic [31:0] imm,
                      input logic [31:0] rd2, input logic [31:0] rd1, input logic [31:0] instr);
    exp_t e;
    e.tag = tag;
    e.val = {c, imm, rd2, rd1, instr};
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic cap();
    exp_t e;
    step();
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty: observed no entry expected one");
    end else begin
      e = sb.pop_front();
      chk(e.tag, IDEXReg, e.val);
    end
  endtask

  task automatic wb(input logic [4:0] r, input logic [31:0] d);
    IFIDReg  = 64'd0;
    MEMWBReg = {1'b0, d, 1'b1, r, 32'd0};
    step();
    MEMWBReg = 71'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset    = 1'b1;
    IFIDReg  = 64'd0;
    MEMWBReg = 71'd0;
    EXMEReg  = 75'd0;
    #3;
    chk("reset_idex", IDEXReg, 136'd0);
    chk("reset_hold", pcHOLD, 1'b0);
    chk("reset_br",   BranchControlSignal, 1'b0);
    chk("reset_tgt",  BranchTarget, 32'd0);
    reset = 1'b0;

    // Write-back with write-through into the same-edge capture
    wb(5'd2, 32'd7);
    IFIDReg  = {I_ADD_3_1_2, 32'd0};
    MEMWBReg = {1'b0, 32'd5, 1'b1, 5'd1, 32'd0};
    settle();
    chk("add_hold", pcHOLD, 1'b0);
    push("add_writethrough", C_RTYPE, 32'h0000_1820, 32'd7, 32'd5, I_ADD_3_1_2);
    cap();

    // $0 stays zero even when written
    IFIDReg  = {I_ADD_3_0_1, 32'd0};
    MEMWBReg = {1'b0, 32'hFFFF_FFFF, 1'b1, 5'd0, 32'd0};
    push("r0_same_cycle", C_RTYPE, 32'h0000_1820, 32'd5, 32'd0, I_ADD_3_0_1);
    cap();
    MEMWBReg = 71'd0;
    push("r0_after", C_RTYPE, 32'h0000_1820, 32'd5, 32'd0, I_ADD_3_0_1);
    cap();

    // Branch taken / not taken
    wb(5'd4, 32'h10);
    wb(5'd5, 32'h10);
    IFIDReg = {I_BEQ_4_5, 32'h0000_0100};
    settle();
    chk("beq_taken",     BranchControlSignal, 1'b1);
    chk("beq_target",    BranchTarget, 32'h0000_00F8);
    chk("beq_nohold",    pcHOLD, 1'b0);
    push("beq_idex", C_BEQ, 32'hFFFF_FFFE, 32'h10, 32'h10, I_BEQ_4_5);
    cap();
    wb(5'd5, 32'h11);
    IFIDReg = {I_BEQ_4_5, 32'h0000_0100};
    settle();
    chk("beq_nottaken",  BranchControlSignal, 1'b0);
    chk("beq_target2",   BranchTarget, 32'h0000_00F8);

    // Branch stall: ID/EX producer of rs
    IFIDReg = {I_ADD_4_1_2, 32'd0};
    push("add4_idex", C_RTYPE, 32'h0000_2020, 32'd7, 32'd5, I_ADD_4_1_2);
    cap();
    IFIDReg = {I_BEQ_4_5, 32'h0000_0100};
    settle();
    chk("br_ex_hold", pcHOLD, 1'b1);
    chk("br_ex_nobr", BranchControlSignal, 1'b0);

    // Branch stall: load in EX/MEM, then EX/MEM forward into comparator
    IFIDReg = 64'd0;
    step();
    IFIDReg = {I_BEQ_4_5, 32'h0000_0100};
    EXMEReg = {2'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd5, 32'h10, 32'd0};
    settle();
    chk("br_mem_hold", pcHOLD, 1'b1);
    chk("br_mem_nobr", BranchControlSignal, 1'b0);
    EXMEReg = {2'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 32'h10, 32'd0};
    settle();
    chk("br_fwd_hold", pcHOLD, 1'b0);
    chk("br_fwd_take", BranchControlSignal, 1'b1);
    EXMEReg = 75'd0;

    // Load-use stall
    IFIDReg = {I_LW_2_1, 32'd0};
    push("lw_idex", C_LW, 32'd0, 32'd7, 32'd5, I_LW_2_1);
    cap();
    IFIDReg = {I_ADD_3_2_1, 32'd0};
    settle();
    chk("lu_hold", pcHOLD, 1'b1);
    push("lu_bubble", C_BUBL, 32'h0000_1820, 32'd5, 32'd7, I_ADD_3_2_1);
    cap();
    chk("lu_release", pcHOLD, 1'b0);
    push("lu_after", C_RTYPE, 32'h0000_1820, 32'd5, 32'd7, I_ADD_3_2_1);
    cap();

    // Forwarding priority
    IFIDReg  = {I_SW_7_6, 32'd0};
    EXMEReg  = {2'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd6, 32'h0000_AAAA, 32'd0};
    MEMWBReg = {1'b0, 32'h0000_BBBB, 1'b1, 5'd6, 32'd0};
    push("fwd_exme", C_SW, 32'd0, 32'd0, 32'h0000_AAAA, I_SW_7_6);
    cap();
    EXMEReg  = {2'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd6, 32'h0000_AAAA, 32'd0};
    settle();
    chk("fwd_load_nohold", pcHOLD, 1'b0);
    push("fwd_memwb", C_SW, 32'd0, 32'd0, 32'h0000_BBBB, I_SW_7_6);
    cap();

    // Async reset between edges
    #2;
    reset = 1'b1;
    #1;
    chk("areset_idex", IDEXReg, 136'd0);
    MEMWBReg = 71'd0;
    EXMEReg  = 75'd0;
    IFIDReg  = {I_ADD_3_4_5, 32'd0};
    settle();
    chk("areset_hold", pcHOLD, 1'b0);
    reset = 1'b0;
    push("post_reset_regs", C_RTYPE, 32'h0000_1820, 32'd0, 32'd0, I_ADD_3_4_5);
    cap();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_writeback_stage.md
# decode_writeback_stage

Instruction-decode and write-back stage of the 5-stage pipelined MIPS core, between the IF/ID and ID/EX pipeline registers. It contains the main control decoder (`Control`), the 32x32 register file with write-back mux, and sign extension. Branch resolution in ID uses `ShiftLeftBranch` plus `adder` for the target and an equality comparator. It also performs load-use/branch hazard detection and ID-stage forwarding, and registers the ID/EX pipeline word.

## Interface
- No parameters.
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-high; clears IDEXReg and all registers.
- `IFIDReg` in 64: [63:32] instruction, [31:0] PC+4 of that instruction.
- `MEMWBReg` in 71: [70] MemtoReg, [69:38] ALU result, [37] RegWrite, [36:32] write register, [31:0] memory read data.
- `EXMEReg` in 75: [74:73] reserved, [72] MemtoReg, [71] MemWrite, [70] MemRead, [69] RegWrite, [68:64] write register, [63:32] ALU result, [31:0] store data.
- `IDEXReg` out 136 (registered): [135] RegDst, [134] MemRead, [133] MemtoReg, [132:131] ALUOp, [130] MemWrite, [129] ALUSrc, [128] RegWrite, [127:96] sign-extended imm, [95:64] read data 2, [63:32] read data 1, [31:0] instruction.
- `BranchControlSignal` out 1: take branch (combinational).
- `BranchTarget` out 32: PC+4 + (signext(imm16) << 2), combinational.
- `pcHOLD` out 1: stall; PC and IF/ID must hold.

## Operation
- Fields: opcode=[31:26], rs=[25:21], rt=[20:16], rd=[15:11], imm=[15:0].
- Control, as {RegDst,MemRead,MemtoReg,ALUOp,MemWrite,ALUSrc,RegWrite,Branch,Jump}:
  - 000000 R-type: RegDst=1, ALUOp=10, RegWrite=1.
  - 100011 lw: MemRead, MemtoReg, ALUSrc, RegWrite; ALUOp=00.
  - 101011 sw: MemWrite, ALUSrc; ALUOp=00.
  - 000100 beq: Branch; ALUOp=01.
  - 001000 addi: ALUSrc, RegWrite; ALUOp=00.
  - 000010 j: Jump only (internal; not exported).
  - Any other opcode: all zero.
- Write-back:
  - WriteData = MEMWBReg[70] ? read data [31:0] : ALU result [69:38].
  - Written to reg MEMWBReg[36:32] on rising clk when [37]=1 and the destination is not 0.
- Register file:
  - Register 0 reads 0 always.
  - Reads are combinational with write-through: a same-cycle MEM/WB write to the read register returns WriteData.
- Forwarding (per operand, rs and rt independently), highest priority first:
  - (1) EX/MEM: RegWrite=1, MemRead=0, dest≠0, dest==src → EXMEReg[63:32].
  - (2) MEM/WB: RegWrite=1, dest≠0, dest==src → WriteData.
  - (3) Register file.
  - Forwarded values feed both the comparator and IDEXReg.
- Hazards: stall (pcHOLD=1) when any of:
  - (a) Load-use: IDEXReg[134]=1 and IDEXReg[20:16] equals rs or rt.
  - (b) Branch in ID, and the ID/EX instruction has RegWrite=1 with dest≠0 equal to rs or rt. Dest = RegDst ? [15:11] : [20:16] of IDEXReg.
  - (c) Branch in ID, and EXMEReg MemRead=1 with dest≠0 equal to rs or rt.
- Stall effects:
  - IDEXReg[135:128] loads 0 (bubble); remaining fields load normally.
  - BranchControlSignal forced 0.
- BranchControlSignal = Branch & (op1 == op2) & ~pcHOLD.
- BranchTarget is computed every cycle regardless of opcode; 32-bit wrap-around add, carry discarded.

## Timing
- IDEXReg updates on every rising clk: bubble when stalled, decoded word otherwise.
- ID-to-EX latency is 1 cycle.
- BranchControlSignal, BranchTarget and pcHOLD are combinational from the current inputs and IDEXReg.
- Register-file write and IDEXReg capture happen on the same edge. Write-through guarantees the captured read data includes that write.
- Reset (async, active-high):
  - IDEXReg = 0 and all 32 registers = 0 immediately; hold while asserted.
  - The combinational outputs follow from the inputs and the zeroed IDEXReg, so pcHOLD=0 with all-zero inputs.
- Reset deassertion mid-stream: the first rising edge after release captures normally.

## Test plan
- Reset, then write-back: MEMWB write of 0x0000_0005 to $1 (RegWrite=1, MemtoReg=0), with IFID = add $3,$1,$2 (0x00221820), $2=7. After the edge, IDEXReg[63:32]=5, [95:64]=7, [135:128]=0b1_0_0_10_0_0_1.
- Write to $0: MEMWB RegWrite=1, dest=0, data 0xFFFF_FFFF. A following read of $0 yields 0.
- Branch taken: $4=$5=0x10, IFID = beq $4,$5,-2 (0x1085FFFE) with PC+4=0x100. Requires BranchControlSignal=1 and BranchTarget=0x0000_00F8. With $5=0x11, BranchControlSignal=0 and the target is unchanged.
- Load-use stall: IDEXReg holds lw $2 (MemRead=1, [20:16]=2); IFID = add $3,$2,$1. Requires pcHOLD=1 and bubble control 0 on the next edge. The cycle after, pcHOLD=0.
- Forwarding priority: EXME writes $6=0xAAAA (RegWrite=1, MemRead=0) and MEMWB writes $6=0xBBBB, with IFID = sw using rs=$6. Requires IDEXReg read data 1 = 0xAAAA. Setting EXME MemRead=1 on a non-branch instruction yields 0xBBBB instead.
- Async reset mid-operation: assert reset between edges. Requires IDEXReg=0 immediately and register reads of 0 afterwards.
